uart_rx: RTL and testbench

//  Serial receiver for the processor's console link; the receive half matching the core's UART transmitter.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and
// default line settings used by the receiver and the future transmitter.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int DATA_BITS   = 8;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115_200;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running prescaler producing a one-clock oversampling tick
// every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-entry valid/ready
// output buffer and framing-error / overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  uart_state_e state;
  logic        rx_m;
  logic        rx_s;
  logic        tick;
  logic        deliver;
  logic [3:0]  sample_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        mid;
  logic        last;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign mid  = (sample_cnt == 4'(MID_SAMPLE));
  assign last = (sample_cnt == 4'(LAST_SAMPLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      deliver    <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      deliver   <= 1'b0;

      if (deliver) begin
        if (!data_valid || data_ready) begin
          data       <= shreg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (tick) begin
        unique case (state)
          IDLE: begin
            // the detecting tick itself counts as sample 0
            if (!rx_s) begin
              state      <= START;
              sample_cnt <= 4'd1;
            end
          end
          START: begin
            if (mid && rx_s) begin
              state <= IDLE;
            end else if (last) begin
              state      <= DATA;
              sample_cnt <= '0;
              bit_idx    <= '0;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          DATA: begin
            if (mid) begin
              shreg <= {rx_s, shreg[7:1]};
            end
            if (last) begin
              sample_cnt <= '0;
              if (bit_idx == 3'(DATA_BITS - 1)) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          STOP: begin
            // leave at mid stop bit so back-to-back frames resync
            if (mid) begin
              if (rx_s) begin
                deliver <= 1'b1;
                state   <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          WAIT_IDLE: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are generated
// from the 8N1 line rules and compared against an expected-byte queue.
module tb_uart_rx;

  localparam int BT = 432;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       data_ready;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  always #10 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         rise_cnt = 0;
  int         hi_cnt   = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         x_cnt    = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = '0;
  logic       vld_q = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if ($isunknown({data, data_valid, frame_err, overrun})) x_cnt++;
    if (data_valid) hi_cnt++;
    if (data_valid && !vld_q) begin
      rise_cnt++;
      rise_data = data;
      rise_cyc  = cyc;
      got_q.push_back(data);
    end
    vld_q = data_valid;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic bitw(logic v, int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(logic [7:0] b, logic stop, int bt);
    bitw(1'b0, bt);
    for (int i = 0; i < 8; i++) bitw(b[i], bt);
    bitw(stop, bt);
  endtask

  task automatic rx_byte_chk(string tag, logic [7:0] b);
    int r0;
    r0 = rise_cnt;
    frame(b, 1'b1, BT);
    bitw(1'b1, 60);
    chk({tag, "_n"}, 32'(rise_cnt - r0), 32'd1);
    chk({tag, "_d"}, 32'(rise_data), 32'(b));
  endtask

  initial begin
    int         r0, h0, f0, o0, x0, st, base, bt;
    logic [7:0] b;

    rx         = 1'b1;
    data_ready = 1'b1;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    rst_n = 1'b1;
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    bitw(1'b1, 20 * BT);
    chk("idle_rise", 32'(rise_cnt - r0), 32'd0);
    chk("idle_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("idle_ovr", 32'(ovr_cnt - o0), 32'd0);

    r0 = rise_cnt; h0 = hi_cnt;
    st = cyc;
    frame(8'h55, 1'b1, BT);
    bitw(1'b1, 60);
    chk("b55_n", 32'(rise_cnt - r0), 32'd1);
    chk("b55_hi", 32'(hi_cnt - h0), 32'd1);
    chk("b55_d", 32'(rise_data), 32'h55);
    chk("b55_lat", 32'((rise_cyc - st >= 4070) && (rise_cyc - st <= 4130)), 32'd1);

    r0 = rise_cnt; f0 = ferr_cnt;
    bitw(1'b0, 100);
    bitw(1'b1, 2 * BT);
    chk("glitch_rise", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    rx_byte_chk("b3c", 8'h3C);

    r0 = rise_cnt; f0 = ferr_cnt;
    frame(8'hA3, 1'b0, BT);
    bitw(1'b0, 2 * BT);
    bitw(1'b1, 2 * BT);
    chk("brk_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("brk_rise", 32'(rise_cnt - r0), 32'd0);
    rx_byte_chk("b0f", 8'h0F);

    data_ready = 1'b0;
    r0 = rise_cnt; o0 = ovr_cnt;
    frame(8'h12, 1'b1, BT);
    frame(8'h34, 1'b1, BT);
    bitw(1'b1, 60);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    chk("ovr_data", 32'(data), 32'h12);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_rise", 32'(rise_cnt - r0), 32'd1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("ovr_drain", 32'(data_valid), 32'd0);
    data_ready = 1'b1;

    b  = 8'h99;
    r0 = rise_cnt; f0 = ferr_cnt;
    bitw(1'b0, BT);
    for (int i = 0; i < 4; i++) bitw(b[i], BT);
    rx = b[4];
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    rst_n = 1'b1;
    bitw(1'b1, 4 * BT);
    chk("mid_rst_rise", 32'(rise_cnt - r0), 32'd0);
    chk("mid_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("mid_rst_data", 32'(data), 32'd0);
    rx_byte_chk("bc8", 8'hC8);

    x0 = x_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          #($urandom_range(3, 700));
          rst_n = ~rst_n;
        end
      end
      begin
        for (int j = 0; j < 3000; j++) begin
          @(negedge clk);
          rx = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    bitw(1'b1, 2 * BT);
    chk("async_x", 32'(x_cnt - x0), 32'd0);
    chk("async_valid", 32'(data_valid), 32'd0);
    b = 8'($urandom);
    rx_byte_chk("post_rst", b);

    base = got_q.size();
    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      bt = $urandom_range(424, 440);
      exp_q.push_back(b);
      frame(b, 1'b1, bt);
      bitw(1'b1, $urandom_range(0, BT));
    end
    bitw(1'b1, 60);
    chk("rand_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < got_q.size())
        chk($sformatf("rand_%0d", k), 32'(got_q[base + k]), 32'(exp_q[k]));
      else
        chk($sformatf("rand_%0d_missing", k), 32'd1, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
